// File: rtl/sumsqr_pkg.sv
// rtl/sumsqr_pkg.sv - shared types and helpers for the sum-of-squares blocks
package sumsqr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sumsqr_accum_state_t;

  localparam int unsigned SAT_INC_MAX_WIDTH = 32;

  // Increment that sticks at the all-ones value of a counter 'width' bits wide.
  // Callers zero-extend into 32 bits and cast the result back down.
  function automatic logic [SAT_INC_MAX_WIDTH-1:0] sat_inc(
    input logic [SAT_INC_MAX_WIDTH-1:0] value,
    input int unsigned                  width
  );
    logic [SAT_INC_MAX_WIDTH-1:0] max_val;
    if (width >= SAT_INC_MAX_WIDTH) begin
      max_val = '1;
    end else begin
      max_val = (32'd1 << width) - 32'd1;
    end
    if (value >= max_val) begin
      return max_val;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - unsigned saturating adder, wide accumulator plus narrower operand
module sat_add #(
  parameter int ACC_WIDTH = 48,
  parameter int WIDTH     = 32
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 sat
);

  logic [ACC_WIDTH:0] wide;

  // One extra bit catches the carry; ACC_WIDTH >= WIDTH is assumed.
  always_comb begin
    wide = {1'b0, acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, operand};
    sat  = wide[ACC_WIDTH];
    sum  = wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0];
  end

endmodule

// File: rtl/sumsqr_accum.sv
// rtl/sumsqr_accum.sv - per-frame saturating accumulator with a one-entry result register
module sumsqr_accum
  import sumsqr_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_sat,
  output logic                 overrun,
  input  logic                 clear_overrun
);

  sumsqr_accum_state_t  state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] count;
  logic                 frame_sat;

  logic [ACC_WIDTH-1:0] add_base;
  logic [ACC_WIDTH-1:0] sum;
  logic                 add_sat;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_sat;
  logic                 sat;
  logic                 load;

  // A beat in IDLE starts from zero, so the same adder serves both states.
  always_comb begin
    add_base = (state == ACCUM) ? acc : '0;
  end

  sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .WIDTH     (WIDTH)
  ) u_sat_add (
    .acc     (add_base),
    .operand (in_data),
    .sum     (sum),
    .sat     (add_sat)
  );

  always_comb begin
    cnt     = CNT_WIDTH'(1);
    cnt_sat = 1'b0;
    sat     = add_sat;
    if (state == ACCUM) begin
      cnt     = CNT_WIDTH'(sat_inc(32'(count), CNT_WIDTH));
      cnt_sat = &count;
      sat     = frame_sat | add_sat | cnt_sat;
    end
    load = in_valid & in_last;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      frame_sat <= 1'b0;
    end else if (in_valid) begin
      if (in_last) begin
        state     <= IDLE;
        acc       <= '0;
        count     <= '0;
        frame_sat <= 1'b0;
      end else begin
        state     <= ACCUM;
        acc       <= sum;
        count     <= cnt;
        frame_sat <= sat;
      end
    end
  end

  // Input side cannot stall: a fresh result always wins, and losing an
  // unaccepted one is recorded in the sticky overrun flag.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= sum;
        out_count <= cnt;
        out_sat   <= sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (load && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sumsqr_accum.sv
// tb/tb_sumsqr_accum.sv - directed bench with a frame-level reference model
module tb_sumsqr_accum;

  logic        clk = 1'b0;
  logic        reset_l = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        clear_overrun = 1'b0;

  logic        ov0, os0, oo0;
  logic [47:0] od0;
  logic [15:0] oc0;
  logic        ov1, os1, oo1;
  logic [7:0]  od1;
  logic [15:0] oc1;

  int nvec = 0;
  int nerr = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  sumsqr_accum #(.WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(16)) dut_wide (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_count(oc0), .out_sat(os0), .overrun(oo0), .clear_overrun(clear_overrun)
  );

  sumsqr_accum #(.WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(16)) dut_narrow (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data[7:0]), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_count(oc1), .out_sat(os1), .overrun(oo1), .clear_overrun(clear_overrun)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: keep the exact frame total and beat count, clamp only when presenting.
  longint unsigned amax [2] = '{64'h0000_FFFF_FFFF_FFFF, 64'd255};
  longint unsigned tot [2] = '{0, 0};
  longint unsigned e_data [2] = '{0, 0};
  int unsigned     beats [2] = '{0, 0};
  int unsigned     e_count [2] = '{0, 0};
  bit              open [2] = '{0, 0};
  bit              e_valid [2] = '{0, 0};
  bit              e_sat [2] = '{0, 0};
  bit              e_ovr [2] = '{0, 0};

  always @(posedge clk or negedge reset_l) begin
    for (int i = 0; i < 2; i++) begin
      longint unsigned d, s;
      int unsigned c;
      if (!reset_l) begin
        tot[i] <= 0; beats[i] <= 0; open[i] <= 1'b0;
        e_valid[i] <= 1'b0; e_data[i] <= 0; e_count[i] <= 0;
        e_sat[i] <= 1'b0; e_ovr[i] <= 1'b0;
      end else begin
        d = (i == 0) ? longint'(in_data) : longint'(in_data[7:0]);
        s = open[i] ? tot[i] + d : d;
        c = open[i] ? beats[i] + 1 : 1;
        if (in_valid && !in_last) begin
          tot[i] <= s; beats[i] <= c; open[i] <= 1'b1;
        end
        if (in_valid && in_last) begin
          open[i] <= 1'b0;
          e_valid[i] <= 1'b1;
          e_data[i] <= (s > amax[i]) ? amax[i] : s;
          e_count[i] <= (c > 65535) ? 65535 : c;
          e_sat[i] <= (s > amax[i]) || (c > 65535);
        end else if (out_ready) begin
          e_valid[i] <= 1'b0;
        end
        if (in_valid && in_last && e_valid[i] && !out_ready) e_ovr[i] <= 1'b1;
        else if (clear_overrun) e_ovr[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("w out_valid", 64'(ov0), 64'(e_valid[0]));
      chk("w overrun", 64'(oo0), 64'(e_ovr[0]));
      chk("n out_valid", 64'(ov1), 64'(e_valid[1]));
      chk("n overrun", 64'(oo1), 64'(e_ovr[1]));
      if (e_valid[0]) begin
        chk("w out_data", 64'(od0), e_data[0]);
        chk("w out_count", 64'(oc0), 64'(e_count[0]));
        chk("w out_sat", 64'(os0), 64'(e_sat[0]));
      end
      if (e_valid[1]) begin
        chk("n out_data", 64'(od1), e_data[1]);
        chk("n out_count", 64'(oc1), 64'(e_count[1]));
        chk("n out_sat", 64'(os1), 64'(e_sat[1]));
      end
    end
  end

  task automatic step(input logic v, input logic l, input logic [31:0] d,
                      input logic rdy = 1'b1, input logic clr = 1'b0);
    in_valid = v; in_last = l; in_data = d; out_ready = rdy; clear_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(ov0), 0);
    chk("reset out_data", 64'(od0), 0);
    chk("reset out_count", 64'(oc0), 0);
    chk("reset out_sat", 64'(os0), 0);
    chk("reset overrun", 64'(oo0), 0);
    reset_l = 1'b1;
    checking = 1'b1;

    step(1, 0, 3); step(1, 0, 4); step(1, 1, 5);
    chk("f345 valid", 64'(ov0), 1);
    chk("f345 data", 64'(od0), 12);
    chk("f345 count", 64'(oc0), 3);
    chk("f345 sat", 64'(os0), 0);
    step(0, 0, 0);
    chk("f345 one-cycle valid", 64'(ov0), 0);

    step(1, 1, 7, 0); step(1, 1, 9, 0);
    chk("ovr data", 64'(od0), 9);
    chk("ovr flag", 64'(oo0), 1);
    step(0, 0, 0, 0, 1);
    chk("clr flag", 64'(oo0), 0);
    chk("clr data kept", 64'(od0), 9);
    chk("clr valid kept", 64'(ov0), 1);

    step(1, 1, 11, 1);
    chk("swap valid", 64'(ov0), 1);
    chk("swap data", 64'(od0), 11);
    chk("swap no ovr", 64'(oo0), 0);
    step(0, 0, 0);

    step(1, 0, 200); step(1, 0, 100); step(1, 1, 10);
    chk("sat8 data", 64'(od1), 255);
    chk("sat8 sat", 64'(os1), 1);
    chk("sat8 count", 64'(oc1), 3);
    chk("sat48 data", 64'(od0), 310);
    chk("sat48 sat", 64'(os0), 0);
    step(0, 0, 0);

    step(1, 0, 1); step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 2); step(0, 0, 0); step(1, 1, 3);
    chk("gap data", 64'(od0), 6);
    chk("gap count", 64'(oc0), 3);
    step(0, 0, 0);

    step(1, 1, 8, 0); step(1, 0, 4, 0); step(1, 0, 6, 0);
    reset_l = 1'b0;
    #1;
    chk("async rst valid", 64'(ov0), 0);
    chk("async rst data", 64'(od0), 0);
    step(0, 0, 0); step(0, 0, 0);
    reset_l = 1'b1;
    step(0, 0, 0);
    chk("post rst valid", 64'(ov0), 0);
    step(1, 1, 5);
    chk("post rst data", 64'(od0), 5);
    chk("post rst count", 64'(oc0), 1);
    step(0, 0, 0);

    step(1, 0, 32'hFFFF_FFFF); step(1, 0, 32'hFFFF_FFFF); step(1, 1, 32'hFFFF_FFFF);
    chk("big data", 64'(od0), 64'h2_FFFF_FFFD);
    chk("big count", 64'(oc0), 3);
    chk("big narrow sat", 64'(os1), 1);
    step(1, 1, 1); step(1, 1, 2);
    chk("b2b single", 64'(od0), 2);
    step(0, 0, 0); step(0, 0, 0);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
